// File: rtl/dump_pkg.sv
// Shared types for the architectural-state dump engine.
package dump_pkg;

  localparam int unsigned DefXlen = 64;
  localparam int unsigned DefIdxW = 5;

  typedef enum logic [1:0] {
    IDLE,
    DUMP_RF,
    DUMP_DM,
    DONE
  } dump_state_e;

  typedef enum logic {
    REG_RF = 1'b0,
    REG_DM = 1'b1
  } dump_region_e;

  typedef struct packed {
    dump_region_e         region;
    logic [DefIdxW-1:0]   idx;
    logic [DefXlen-1:0]   data;
  } dump_beat_t;

  // Index width covering the larger region, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned rf_depth,
                                            input int unsigned dm_depth);
    int unsigned m;
    m = (rf_depth > dm_depth) ? rf_depth : dm_depth;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dump_trig_cnt.sv
// Saturating post-reset cycle counter; pulses auto_trig_o once when it reaches TRIG_CYCLES.
module dump_trig_cnt #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TRIG_CYCLES = 20
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic auto_trig_o
);

  localparam logic [CNT_W-1:0] TrigVal = CNT_W'(TRIG_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fired_q, fired_d;
  logic             hit;

  // The fired flag keeps the pulse single-cycle even if the count saturates on TrigVal.
  assign hit         = (TRIG_CYCLES != 0) && (cnt_q == TrigVal) && !fired_q;
  assign auto_trig_o = hit;

  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q | hit;
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

endmodule

// File: rtl/arch_state_dump.sv
// Halts the core and streams RF then DMEM contents over a valid/ready channel.
module arch_state_dump
  import dump_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned RF_DEPTH    = 32,
  parameter int unsigned DM_DEPTH    = 8,
  parameter int unsigned TRIG_CYCLES = 20,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned IDX_W       = idx_width(RF_DEPTH, DM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig_req,
  output logic             cpu_halt,
  output logic [IDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic [IDX_W-1:0] dm_raddr,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_region,
  output logic [IDX_W-1:0] out_idx,
  output logic [XLEN-1:0]  out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] RfLast = IDX_W'(RF_DEPTH - 1);
  localparam logic [IDX_W-1:0] DmLast = IDX_W'(DM_DEPTH - 1);

  dump_state_e      state_q, state_d;
  dump_region_e     region_q, region_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             halt_q, halt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             auto_trig;
  logic             can_load;

  dump_trig_cnt #(
    .CNT_W       (CNT_W),
    .TRIG_CYCLES (TRIG_CYCLES)
  ) u_trig_cnt (
    .clk_i       (clk),
    .reset_i     (reset),
    .auto_trig_o (auto_trig)
  );

  assign can_load = !valid_q || out_ready;

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    idx_d    = idx_q;
    oidx_d   = oidx_q;
    data_d   = data_q;
    halt_d   = halt_q;
    valid_d  = valid_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (trig_req || auto_trig) begin
          state_d = DUMP_RF;
          halt_d  = 1'b1;
          idx_d   = '0;
        end
      end
      DUMP_RF: begin
        if (can_load) begin
          valid_d  = 1'b1;
          region_d = REG_RF;
          oidx_d   = idx_q;
          data_d   = rf_rdata;
          if (idx_q == RfLast) begin
            state_d = DUMP_DM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_DM: begin
        // Once the final entry is loaded, only its acceptance remains.
        if (last_q) begin
          if (out_ready) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            halt_d  = 1'b0;
          end
        end else if (can_load) begin
          valid_d  = 1'b1;
          region_d = REG_DM;
          oidx_d   = idx_q;
          data_d   = dm_rdata;
          if (idx_q == DmLast) begin
            last_d = 1'b1;
            idx_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (trig_req) begin
          state_d = DUMP_RF;
          halt_d  = 1'b1;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      region_q <= REG_RF;
      idx_q    <= '0;
      oidx_q   <= '0;
      data_q   <= '0;
      halt_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      idx_q    <= idx_d;
      oidx_q   <= oidx_d;
      data_q   <= data_d;
      halt_q   <= halt_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign cpu_halt   = halt_q;
  assign rf_raddr   = idx_q;
  assign dm_raddr   = idx_q;
  assign out_valid  = valid_q;
  assign out_region = region_q;
  assign out_idx    = oidx_q;
  assign out_data   = data_q;
  assign out_last   = last_q;
  assign busy       = (state_q == DUMP_RF) || (state_q == DUMP_DM);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_arch_state_dump.sv
// Bench for arch_state_dump: a default instance (a) and a small 4+1 entry, 32-bit instance (b).
module tb_arch_state_dump;

  logic        clk = 1'b0;
  logic [1:0]  r_reset, r_trig, r_ready;
  logic [1:0]  o_valid, o_halt, o_busy, o_done, o_last, o_region;
  logic [4:0]  rf_raddr_a, dm_raddr_a, o_idx_a;
  logic [1:0]  rf_raddr_b, dm_raddr_b, o_idx_b;
  logic [63:0] rf_rdata_a, dm_rdata_a, o_data_a;
  logic [31:0] rf_rdata_b, dm_rdata_b, o_data_b;

  // Stream image per instance: beat k is RF[k] for k < RF depth, else DMEM[k - RF depth].
  logic [63:0] mem [2][64];

  int m_cnt [2];
  int m_phase [2];  // 0 waiting for trigger, 1 dumping, 2 finished
  int m_pos [2];
  int m_valid [2];
  int beats [2];
  int rmode [2];
  int rcnt [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata_a = mem[0][{1'b0, rf_raddr_a}];
  assign dm_rdata_a = mem[0][{1'b1, dm_raddr_a}];
  assign rf_rdata_b = mem[1][{4'b0000, rf_raddr_b}][31:0];
  assign dm_rdata_b = mem[1][{4'b0001, dm_raddr_b}][31:0];

  arch_state_dump u_dut_a (
    .clk        (clk),
    .reset      (r_reset[0]),
    .trig_req   (r_trig[0]),
    .cpu_halt   (o_halt[0]),
    .rf_raddr   (rf_raddr_a),
    .rf_rdata   (rf_rdata_a),
    .dm_raddr   (dm_raddr_a),
    .dm_rdata   (dm_rdata_a),
    .out_valid  (o_valid[0]),
    .out_ready  (r_ready[0]),
    .out_region (o_region[0]),
    .out_idx    (o_idx_a),
    .out_data   (o_data_a),
    .out_last   (o_last[0]),
    .busy       (o_busy[0]),
    .done       (o_done[0])
  );

  arch_state_dump #(
    .XLEN        (32),
    .RF_DEPTH    (4),
    .DM_DEPTH    (1),
    .TRIG_CYCLES (0)
  ) u_dut_b (
    .clk        (clk),
    .reset      (r_reset[1]),
    .trig_req   (r_trig[1]),
    .cpu_halt   (o_halt[1]),
    .rf_raddr   (rf_raddr_b),
    .rf_rdata   (rf_rdata_b),
    .dm_raddr   (dm_raddr_b),
    .dm_rdata   (dm_rdata_b),
    .out_valid  (o_valid[1]),
    .out_ready  (r_ready[1]),
    .out_region (o_region[1]),
    .out_idx    (o_idx_b),
    .out_data   (o_data_b),
    .out_last   (o_last[1]),
    .busy       (o_busy[1]),
    .done       (o_done[1])
  );

  function automatic int n_of(input int d);
    return (d == 0) ? 40 : 5;
  endfunction

  function automatic int rf_of(input int d);
    return (d == 0) ? 32 : 4;
  endfunction

  function automatic int trig_of(input int d);
    return (d == 0) ? 20 : 0;
  endfunction

  function automatic logic [63:0] g_idx(input int d);
    return (d == 0) ? {59'b0, o_idx_a} : {62'b0, o_idx_b};
  endfunction

  function automatic logic [63:0] g_data(input int d);
    return (d == 0) ? o_data_a : {32'b0, o_data_b};
  endfunction

  function automatic logic [63:0] g_raddr(input int d, input bit dm);
    if (d == 0) return dm ? {59'b0, dm_raddr_a} : {59'b0, rf_raddr_a};
    return dm ? {62'b0, dm_raddr_b} : {62'b0, rf_raddr_b};
  endfunction

  function automatic logic [63:0] exp_data(input int d, input int pos);
    return (d == 0) ? mem[0][6'(pos)] : {32'b0, mem[1][6'(pos)][31:0]};
  endfunction

  // Stream-level reference: counts cycles, decides triggers, walks the beat position.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (r_reset[d]) begin
        m_cnt[d]   <= 0;
        m_phase[d] <= 0;
        m_valid[d] <= 0;
        m_pos[d]   <= 0;
      end else begin
        m_cnt[d] <= m_cnt[d] + 1;
        if (o_valid[d] && r_ready[d]) beats[d] <= beats[d] + 1;
        if (m_phase[d] == 0) begin
          if (r_trig[d] || (trig_of(d) != 0 && m_cnt[d] == trig_of(d))) begin
            m_phase[d] <= 1;
            m_pos[d]   <= 0;
            m_valid[d] <= 0;
          end
        end else if (m_phase[d] == 1) begin
          if (m_valid[d] == 0 || r_ready[d]) begin
            if (m_valid[d] != 0 && m_pos[d] == n_of(d) - 1) begin
              m_phase[d] <= 2;
              m_valid[d] <= 0;
            end else begin
              m_valid[d] <= 1;
              if (m_valid[d] != 0) m_pos[d] <= m_pos[d] + 1;
            end
          end
        end else if (r_trig[d]) begin
          m_phase[d] <= 1;
          m_pos[d]   <= 0;
        end
      end
    end
  end

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic cmp_all();
    int pos;
    int rf;
    for (int d = 0; d < 2; d++) begin
      chk1($sformatf("dut%0d out_valid", d), o_valid[d], m_valid[d] != 0);
      chk1($sformatf("dut%0d cpu_halt", d), o_halt[d], m_phase[d] == 1);
      chk1($sformatf("dut%0d busy", d), o_busy[d], m_phase[d] == 1);
      chk1($sformatf("dut%0d done", d), o_done[d], m_phase[d] == 2);
      if (m_valid[d] != 0) begin
        pos = m_pos[d];
        rf  = rf_of(d);
        chk1($sformatf("dut%0d out_region beat %0d", d, pos), o_region[d], pos >= rf);
        chkw($sformatf("dut%0d out_idx beat %0d", d, pos), g_idx(d),
             64'((pos < rf) ? pos : pos - rf));
        chkw($sformatf("dut%0d out_data beat %0d", d, pos), g_data(d), exp_data(d, pos));
        chk1($sformatf("dut%0d out_last beat %0d", d, pos), o_last[d], pos == n_of(d) - 1);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_all();
    for (int d = 0; d < 2; d++) begin
      case (rmode[d])
        0:       r_ready[d] = 1'b1;
        1:       r_ready[d] = (rcnt[d] % 4 == 0) || (rcnt[d] % 4 == 3);
        default: r_ready[d] = 1'($urandom_range(0, 1));
      endcase
      rcnt[d]++;
    end
  endtask

  task automatic wait_done(input int d, input int bound);
    int n = 0;
    while (!o_done[d] && n < bound) begin
      step();
      n++;
    end
    chk1($sformatf("dut%0d done within %0d cycles", d, bound), o_done[d], 1'b1);
  endtask

  task automatic chk_reset_state(input int d);
    chk1($sformatf("dut%0d reset out_valid", d), o_valid[d], 1'b0);
    chk1($sformatf("dut%0d reset cpu_halt", d), o_halt[d], 1'b0);
    chk1($sformatf("dut%0d reset busy", d), o_busy[d], 1'b0);
    chk1($sformatf("dut%0d reset done", d), o_done[d], 1'b0);
    chk1($sformatf("dut%0d reset out_last", d), o_last[d], 1'b0);
    chk1($sformatf("dut%0d reset out_region", d), o_region[d], 1'b0);
    chkw($sformatf("dut%0d reset out_idx", d), g_idx(d), 64'd0);
    chkw($sformatf("dut%0d reset out_data", d), g_data(d), 64'd0);
    chkw($sformatf("dut%0d reset rf_raddr", d), g_raddr(d, 1'b0), 64'd0);
    chkw($sformatf("dut%0d reset dm_raddr", d), g_raddr(d, 1'b1), 64'd0);
  endtask

  task automatic fill_rand(input int d);
    for (int k = 0; k < 64; k++) mem[d][k] = {$urandom, $urandom};
  endtask

  initial begin
    int base;
    int n;
    r_reset = 2'b11;
    r_trig  = 2'b00;
    r_ready = 2'b11;
    rmode   = '{0, 2};
    rcnt    = '{0, 0};
    for (int k = 0; k < 64; k++) mem[0][k] = (k < 32) ? 64'(k) * 64'h1111 : 64'h0;
    for (int k = 0; k < 8; k++) mem[0][32 + k] = 64'hA0 + 64'(k);
    fill_rand(1);

    repeat (3) step();
    chk_reset_state(0);
    chk_reset_state(1);

    // Default instance auto-dumps at edge 20; instance b is pulsed at edge 5.
    r_reset = 2'b00;
    for (int e = 0; e < 62; e++) begin
      step();
      case (e)
        4: begin
          chk1("b halt before manual trigger", o_halt[1], 1'b0);
          r_trig[1] = 1'b1;
        end
        5: begin
          r_trig[1] = 1'b0;
          chk1("b halt after trigger edge", o_halt[1], 1'b1);
        end
        6: begin
          chk1("b first beat valid", o_valid[1], 1'b1);
          chkw("b first beat idx", g_idx(1), 64'd0);
        end
        19: chk1("a halt before auto trigger", o_halt[0], 1'b0);
        20: begin
          chk1("a halt after auto trigger", o_halt[0], 1'b1);
          chk1("a no beat yet", o_valid[0], 1'b0);
        end
        21: begin
          chk1("a RF0 valid", o_valid[0], 1'b1);
          chkw("a RF0 data", g_data(0), 64'h0);
        end
        29: chkw("a RF8 data", g_data(0), 64'h8888);
        60: begin
          chkw("a last beat data", g_data(0), 64'hA7);
          chkw("a last beat idx", g_idx(0), 64'd7);
          chk1("a last beat region", o_region[0], 1'b1);
          chk1("a last beat flag", o_last[0], 1'b1);
        end
        61: begin
          chk1("a done after dump", o_done[0], 1'b1);
          chk1("a halt released", o_halt[0], 1'b0);
          chkw("a beat count first dump", 64'(beats[0]), 64'd40);
        end
        default: ;
      endcase
    end
    wait_done(1, 200);
    chkw("b beat count first dump", 64'(beats[1]), 64'd5);

    // Ready pattern 1,0,0,1 with fresh contents.
    rmode[0] = 1;
    fill_rand(0);
    base = beats[0];
    r_trig[0] = 1'b1;
    step();
    r_trig[0] = 1'b0;
    wait_done(0, 400);
    chkw("a beat count stall pattern", 64'(beats[0] - base), 64'd40);

    // Instance b retrigger from DONE with ready high: exact beat timing.
    rmode[1]   = 0;
    r_ready[1] = 1'b1;
    fill_rand(1);
    r_trig[1] = 1'b1;
    step();
    r_trig[1] = 1'b0;
    chk1("b retrigger halt", o_halt[1], 1'b1);
    chk1("b retrigger no beat yet", o_valid[1], 1'b0);
    step();
    chkw("b beat0 data", g_data(1), {32'b0, mem[1][0][31:0]});
    repeat (3) step();
    chkw("b RF3 idx", g_idx(1), 64'd3);
    chk1("b RF3 region", o_region[1], 1'b0);
    chk1("b RF3 not last", o_last[1], 1'b0);
    step();
    chkw("b DM0 idx", g_idx(1), 64'd0);
    chk1("b DM0 region", o_region[1], 1'b1);
    chk1("b DM0 last", o_last[1], 1'b1);
    chkw("b DM0 data", g_data(1), {32'b0, mem[1][4][31:0]});
    step();
    chk1("b done after 5 beats", o_done[1], 1'b1);
    chk1("b halt released", o_halt[1], 1'b0);

    // Request held through a dump is ignored; a pulse in DONE restarts.
    rmode[0] = 2;
    fill_rand(0);
    base = beats[0];
    r_trig[0] = 1'b1;
    repeat (30) step();
    r_trig[0] = 1'b0;
    wait_done(0, 400);
    chkw("a beat count trig held", 64'(beats[0] - base), 64'd40);
    fill_rand(0);
    base = beats[0];
    r_trig[0] = 1'b1;
    step();
    r_trig[0] = 1'b0;
    wait_done(0, 400);
    chkw("a beat count retrigger", 64'(beats[0] - base), 64'd40);

    // Reset mid-dump after the 10th accepted beat, then auto-trigger again.
    rmode[0] = 0;
    base = beats[0];
    r_trig[0] = 1'b1;
    step();
    r_trig[0] = 1'b0;
    n = 0;
    while (beats[0] - base < 10 && n < 100) begin
      step();
      n++;
    end
    chkw("a beats before reset", 64'(beats[0] - base), 64'd10);
    r_reset[0] = 1'b1;
    step();
    chk_reset_state(0);
    step();
    r_reset[0] = 1'b0;
    base = beats[0];
    repeat (20) step();
    chk1("a halt before re-fire", o_halt[0], 1'b0);
    step();
    chk1("a halt after re-fire", o_halt[0], 1'b1);
    step();
    chk1("a RF0 after re-fire", o_valid[0], 1'b1);
    chkw("a RF0 idx after re-fire", g_idx(0), 64'd0);
    wait_done(0, 200);
    chkw("a beat count after reset", 64'(beats[0] - base), 64'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_state_dump.md
# arch_state_dump

Synthesizable architectural-state dump engine for the single-cycle CPU, a parametrised, hardware-resident successor to the end-of-simulation register-file/data-memory dump. After a programmable cycle count, or on an explicit request, it halts the core. It then walks the register-file and data-memory read ports in order and streams every entry out over a valid/ready channel. It sits beside `single_cycle_cpu`, sharing its debug read ports, and feeds a trace sink, UART bridge or testbench monitor.

## Interface
- `XLEN`, 64, data width of RF and DMEM entries
- `RF_DEPTH`, 32, register-file entries dumped (≥1)
- `DM_DEPTH`, 8, data-memory words dumped (≥1)
- `TRIG_CYCLES`, 20, auto-trigger cycle count after reset; 0 disables auto-trigger
- `CNT_W`, 32, cycle-counter width
- `IDX_W`, $clog2(max(RF_DEPTH,DM_DEPTH)), index width (derived, minimum 1)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `trig_req`  in  1  manual dump request, sampled in IDLE and DONE
- `cpu_halt`  out  1  stalls the CPU PC/writeback while dumping
- `rf_raddr`  out  IDX_W  RF debug read address
- `rf_rdata`  in  XLEN  RF debug read data, combinational from `rf_raddr`
- `dm_raddr`  out  IDX_W  DMEM debug word address
- `dm_rdata`  in  XLEN  DMEM debug read data, combinational from `dm_raddr`
- `out_valid`  out  1  stream entry valid
- `out_ready`  in  1  sink accepts entry
- `out_region`  out  1  0 = RF, 1 = DMEM
- `out_idx`  out  IDX_W  entry index within region
- `out_data`  out  XLEN  entry value
- `out_last`  out  1  final entry (DMEM[DM_DEPTH-1])
- `busy`  out  1  state is DUMP_RF or DUMP_DM
- `done`  out  1  state is DONE

## Operation
- States: IDLE → DUMP_RF → DUMP_DM → DONE. DONE → DUMP_RF on `trig_req`; retriggering is allowed.
- IDLE: the cycle counter increments each cycle and saturates at all-ones. The machine moves to DUMP_RF when `trig_req` = 1 or when the counter equals `TRIG_CYCLES` (≠0). The counter is not cleared when it fires, so the auto-trigger fires once per reset.
- On entering DUMP_RF: `cpu_halt` = 1 and the read index = 0.
- Load condition in a dump state: `!out_valid || out_ready`. While entries remain, the output register loads {region, idx, rdata} and the index increments.
- RF index reaching `RF_DEPTH-1` with a load moves the machine to DUMP_DM with index 0. The last DMEM load sets `out_last` and moves to DONE once that entry is accepted.
- DONE: `cpu_halt` = 0 and `out_valid` = 0. `done` stays high until retrigger or reset.
- `trig_req` is ignored during DUMP_*.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0, all `out_*` and the read index hold stable.
- Reset (any state, including mid-dump): state IDLE, counter 0, index 0. Outputs reset to `cpu_halt` 0, `out_valid` 0, `out_last` 0, `out_data` 0, `out_idx` 0, `out_region` 0, `busy` 0, `done` 0, `rf_raddr` 0, `dm_raddr` 0.

## Timing
- Trigger sampled at edge t. At t+1: state DUMP_RF, `cpu_halt` = 1, `rf_raddr` = 0. At t+2: `out_valid` = 1 with RF[0].
- With `out_ready` held high, throughput is 1 entry per cycle: RF_DEPTH+DM_DEPTH valid cycles, back-to-back, RF then DMEM.
- `cpu_halt` stays high from t+1 through the cycle the `out_last` beat is accepted. It falls the following edge.
- The read data path is combinational within one cycle: address register → port → output register.
- Auto-trigger with `TRIG_CYCLES` = N, reset released at edge 0: trigger edge is N, so RF[0] appears at edge N+2.

## Structure
- Package `dump_pkg` holds:
  - `dump_state_e` (IDLE, DUMP_RF, DUMP_DM, DONE)
  - `dump_region_e` (REG_RF = 0, REG_DM = 1)
  - `dump_beat_t` struct {region, idx, data}, parametrised via localparams mirroring `XLEN`/`IDX_W` defaults
- One sub-module: `dump_trig_cnt`, the saturating cycle counter plus compare, producing a single-cycle `auto_trig` pulse.
- The FSM, index register and output register stay in `arch_state_dump`.

## Test plan
- Defaults, `out_ready` = 1, RF[i] = i·0x1111, DMEM[i] = 0xA0+i, reset released at edge 0 → RF[0] at edge 22, then 40 consecutive beats. `out_last` is set only on DMEM[7] = 0xA7. `done` = 1 and `cpu_halt` = 0 afterwards.
- `out_ready` toggles 1,0,0,1 repeating → no beat dropped or duplicated. `out_data` stays stable across stall cycles, and the sequence order is identical to the first case.
- `TRIG_CYCLES` = 0, `trig_req` pulsed at edge 5 → no auto-dump before edge 5. `cpu_halt` rises at edge 6 and RF[0] appears at edge 7.
- `trig_req` held high through a dump, then pulsed in DONE → the mid-dump request is ignored (exactly 40 beats), and the DONE pulse starts a second full 40-beat dump.
- `reset` asserted after the 10th accepted beat → next edge shows `out_valid` 0, `cpu_halt` 0, state IDLE. An auto-dump re-fires `TRIG_CYCLES` cycles after reset release.
- `RF_DEPTH` = 4, `DM_DEPTH` = 1, `XLEN` = 32 → 5 beats, with `out_last` on DMEM[0] and the region switching after idx 3.
